// File: rtl/uart_rx_if.sv
// uart_rx host-side bundle: enable in, received byte and status pulses out.
interface uart_rx_if;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    modport master (
        input  Rx_EN,
        output Rx_DATA,
        output Rx_VALID,
        output Rx_PERROR,
        output Rx_FERROR,
        output Rx_BUSY
    );

    modport slave (
        output Rx_EN,
        input  Rx_DATA,
        input  Rx_VALID,
        input  Rx_PERROR,
        input  Rx_FERROR,
        input  Rx_BUSY
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8E1 frames, MSB first,
// result delivered as one-cycle valid/parity/frame pulses.
module uart_rx #(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_sample_ENABLE,
    input  logic       RxD,
    uart_rx_if.master  bus
);

    localparam logic [3:0] HALF = 4'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [3:0] LAST = 4'(SAMPLES_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic rxd_s;
    logic rxd_d, rxd_d_n;

    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sr_q, sr_d;
    logic       par_q, par_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
        end
    end

    // rxd_d is refreshed only on ticks so an edge between ticks is still seen
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rxd_d   <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rxd_d   <= rxd_d_n;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rxd_d_n = rxd_d;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (Rx_sample_ENABLE) begin
            rxd_d_n = rxd_s;
            unique case (state_q)
                IDLE: begin
                    if (rxd_d && !rxd_s) begin
                        tick_d  = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (tick_q == HALF) begin
                        tick_d = '0;
                        if (!rxd_s) begin
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_q == LAST) begin
                        sr_d   = {sr_q[6:0], rxd_s};
                        tick_d = '0;
                        if (bit_q == 3'd7) begin
                            state_d = PARITY;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                PARITY: begin
                    if (tick_q == LAST) begin
                        par_d   = rxd_s;
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                STOP: begin
                    if (tick_q == LAST) begin
                        data_d  = sr_q;
                        tick_d  = '0;
                        state_d = IDLE;
                        // a bad stop bit masks any parity result
                        if (!rxd_s) begin
                            ferr_d = 1'b1;
                        end else if ((^sr_q) != par_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (!bus.Rx_EN) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
            data_d  = data_q;
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    assign bus.Rx_DATA   = data_q;
    assign bus.Rx_VALID  = valid_q;
    assign bus.Rx_PERROR = perr_q;
    assign bus.Rx_FERROR = ferr_q;
    assign bus.Rx_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard of expected result pulses.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset;
    logic Rx_sample_ENABLE = 1'b0;
    logic RxD;
    logic tick_seen = 1'b0;
    int   div = 0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PERR  = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];

    uart_rx_if bus();

    uart_rx #(
        .SAMPLES_PER_BIT(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Rx_sample_ENABLE(Rx_sample_ENABLE),
        .RxD(RxD),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // one sample tick every third clock
    always @(negedge clk) begin
        div = (div == 2) ? 0 : div + 1;
        Rx_sample_ENABLE = (div == 0);
    end

    always @(posedge clk) tick_seen <= Rx_sample_ENABLE;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] k;
        exp_t e;
        k = {bus.Rx_VALID, bus.Rx_PERROR, bus.Rx_FERROR};
        if (k !== 3'b000) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {29'd0, k}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", {29'd0, k}, {29'd0, e.kind});
                chk("pulse_data", {24'd0, bus.Rx_DATA}, {24'd0, e.data});
                chk("pulse_latency", {31'd0, tick_seen}, 32'd1);
            end
        end
    end

    task automatic tk();
        do @(posedge clk); while (Rx_sample_ENABLE !== 1'b1);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d,
                                       input logic p, input logic s);
        return {1'b0, d, p, s};
    endfunction

    task automatic send(input logic [10:0] f, input int nbits);
        for (int i = 10; i > 10 - nbits; i--) begin
            RxD = f[i];
            repeat (16) tk();
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, sbq.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b1;
        RxD = 1'b1;
        bus.Rx_EN = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.Rx_BUSY}, 32'd0);
        chk("rst_valid", {31'd0, bus.Rx_VALID}, 32'd0);
        chk("rst_perr", {31'd0, bus.Rx_PERROR}, 32'd0);
        chk("rst_ferr", {31'd0, bus.Rx_FERROR}, 32'd0);
        chk("rst_data", {24'd0, bus.Rx_DATA}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 200; i++) begin
            tk();
            if (bus.Rx_BUSY !== 1'b0)
                chk("idle_busy", {31'd0, bus.Rx_BUSY}, 32'd0);
        end
        chk("idle_busy_end", {31'd0, bus.Rx_BUSY}, 32'd0);
        chk("idle_data", {24'd0, bus.Rx_DATA}, 32'd0);

        d = 8'hA5;
        push(K_VALID, d);
        send(mk(d, ^d, 1'b1), 11);
        RxD = 1'b1;
        chk_drained("a5_drained");
        chk("a5_data", {24'd0, bus.Rx_DATA}, 32'hA5);
        chk("a5_busy", {31'd0, bus.Rx_BUSY}, 32'd0);

        d = 8'h3C;
        push(K_PERR, d);
        send(mk(d, 1'b1, 1'b1), 11);
        RxD = 1'b1;
        chk_drained("3c_drained");
        chk("3c_data", {24'd0, bus.Rx_DATA}, 32'h3C);

        d = 8'hFF;
        push(K_FERR, d);
        send(mk(d, ^d, 1'b0), 11);
        for (int i = 0; i < 40; i++) begin
            tk();
            if (bus.Rx_BUSY !== 1'b0)
                chk("low_busy", {31'd0, bus.Rx_BUSY}, 32'd0);
        end
        chk_drained("ff_drained");
        chk("ff_data", {24'd0, bus.Rx_DATA}, 32'hFF);
        chk("low_no_start", {31'd0, bus.Rx_BUSY}, 32'd0);
        RxD = 1'b1;
        repeat (4) tk();
        d = 8'h5A;
        push(K_VALID, d);
        send(mk(d, ^d, 1'b1), 11);
        RxD = 1'b1;
        chk_drained("5a_drained");
        chk("5a_data", {24'd0, bus.Rx_DATA}, 32'h5A);

        RxD = 1'b0;
        repeat (4) tk();
        RxD = 1'b1;
        tk();
        chk("glitch_busy", {31'd0, bus.Rx_BUSY}, 32'd1);
        repeat (12) tk();
        chk("glitch_idle", {31'd0, bus.Rx_BUSY}, 32'd0);
        chk("glitch_data", {24'd0, bus.Rx_DATA}, 32'h5A);

        d = 8'h81;
        send(mk(d, ^d, 1'b1), 4);
        RxD = 1'b0;
        repeat (8) tk();
        chk("en_busy_pre", {31'd0, bus.Rx_BUSY}, 32'd1);
        bus.Rx_EN = 1'b0;
        tk();
        chk("en_busy_off", {31'd0, bus.Rx_BUSY}, 32'd0);
        RxD = 1'b1;
        repeat (20) tk();
        bus.Rx_EN = 1'b1;
        repeat (5) tk();
        chk("en_busy_idle", {31'd0, bus.Rx_BUSY}, 32'd0);
        chk("en_data_kept", {24'd0, bus.Rx_DATA}, 32'h5A);
        d = 8'h42;
        push(K_VALID, d);
        send(mk(d, ^d, 1'b1), 11);
        RxD = 1'b1;
        chk_drained("42_drained");
        chk("42_data", {24'd0, bus.Rx_DATA}, 32'h42);

        d = 8'h81;
        send(mk(d, ^d, 1'b1), 5);
        chk("rstmid_busy_pre", {31'd0, bus.Rx_BUSY}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_busy", {31'd0, bus.Rx_BUSY}, 32'd0);
        chk("rstmid_data", {24'd0, bus.Rx_DATA}, 32'd0);
        chk("rstmid_pulses",
            {29'd0, bus.Rx_VALID, bus.Rx_PERROR, bus.Rx_FERROR}, 32'd0);
        RxD = 1'b1;
        reset = 1'b0;
        repeat (20) tk();
        chk("rstmid_idle", {31'd0, bus.Rx_BUSY}, 32'd0);

        d = 8'hC3;
        push(K_VALID, d);
        send(mk(d, ^d, 1'b1), 11);
        RxD = 1'b1;
        repeat (4) tk();
        chk_drained("c3_drained");
        chk("c3_data", {24'd0, bus.Rx_DATA}, 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
